lr_car_detector: RTL and testbench



---
 rtl/tlc_pkg.sv | 15 +
 rtl/sensor_debounce.sv | 99 +++++++++
 rtl/lr_car_detector.sv | 82 ++++++++
 tb/tb_lr_car_detector.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared traffic-light-controller definitions: debounce state encoding and default timing constants.
package tlc_pkg;

  typedef enum logic [1:0] {
    DEB_LOW  = 2'd0,
    DEB_RISE = 2'd1,
    DEB_HIGH = 2'd2,
    DEB_FALL = 2'd3
  } deb_state_t;

  localparam int DEF_DEB_CYCLES  = 4;
  localparam int DEF_MAX_CARS    = 15;
  localparam int DEF_HOLD_CYCLES = 3;

endpackage

// File: rtl/sensor_debounce.sv
// Loop sensor conditioning: 2-flop sync, debounce FSM, registered rising-edge hit.
// Hit appears DEB_CYCLES+1 edges after raw is first sampled high; no backpressure.
module sensor_debounce
  import tlc_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic hit
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic       s1, s2;
  deb_state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       hit_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= DEB_LOW;
      cnt   <= 8'd0;
      hit   <= 1'b0;
    end else begin
      s1    <= raw_in;
      s2    <= s1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hit   <= hit_nxt;
    end
  end

  // A single-sample debounce skips the transient states entirely.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hit_nxt   = 1'b0;
    case (state)
      DEB_LOW: begin
        if (s2) begin
          if (DEB_LAST == 8'd0) begin
            state_nxt = DEB_HIGH;
            cnt_nxt   = 8'd0;
            hit_nxt   = 1'b1;
          end else begin
            state_nxt = DEB_RISE;
            cnt_nxt   = 8'd1;
          end
        end
      end
      DEB_RISE: begin
        if (!s2) begin
          state_nxt = DEB_LOW;
          cnt_nxt   = 8'd0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = DEB_HIGH;
          cnt_nxt   = 8'd0;
          hit_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DEB_HIGH: begin
        if (!s2) begin
          if (DEB_LAST == 8'd0) begin
            state_nxt = DEB_LOW;
            cnt_nxt   = 8'd0;
          end else begin
            state_nxt = DEB_FALL;
            cnt_nxt   = 8'd1;
          end
        end
      end
      DEB_FALL: begin
        if (s2) begin
          state_nxt = DEB_HIGH;
          cnt_nxt   = 8'd0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = DEB_LOW;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = DEB_LOW;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  assign level = (state == DEB_HIGH) || (state == DEB_FALL);

endmodule

// File: rtl/lr_car_detector.sv
// Local-road car presence: debounced arrival/departure loops drive a saturating queue count plus hold-off.
// car_count moves DEB_CYCLES+2 edges after a clean raw edge; no backpressure, err is sticky until rst.
module lr_car_detector
  import tlc_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int MAX_CARS    = DEF_MAX_CARS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arrive_raw,
  input  logic             depart_raw,
  output logic             lr_has_car,
  output logic [CNT_W-1:0] car_count,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CARS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       HOLD_INIT = 8'(HOLD_CYCLES);

  logic             arrive_hit, depart_hit;
  logic             arrive_level, depart_level;
  logic             unused_levels;
  logic [CNT_W-1:0] count_nxt;
  logic             err_set;
  logic [7:0]       hold, hold_nxt;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_arrive (
    .clk    (clk),
    .rst    (rst),
    .raw_in (arrive_raw),
    .level  (arrive_level),
    .hit    (arrive_hit)
  );

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_depart (
    .clk    (clk),
    .rst    (rst),
    .raw_in (depart_raw),
    .level  (depart_level),
    .hit    (depart_hit)
  );

  // Levels are only of interest to debug taps.
  assign unused_levels = arrive_level ^ depart_level;

  // Simultaneous hits cancel: one car in, one car out.
  always_comb begin
    count_nxt = car_count;
    err_set   = 1'b0;
    if (arrive_hit && !depart_hit) begin
      if (car_count < MAX_CNT) count_nxt = car_count + CNT_ONE;
      else                     err_set   = 1'b1;
    end else if (depart_hit && !arrive_hit) begin
      if (car_count != '0) count_nxt = car_count - CNT_ONE;
      else                 err_set   = 1'b1;
    end

    hold_nxt = hold;
    if (count_nxt != '0)          hold_nxt = 8'd0;
    else if (car_count == CNT_ONE) hold_nxt = HOLD_INIT;
    else if (hold != 8'd0)         hold_nxt = hold - 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_count <= '0;
      err       <= 1'b0;
      hold      <= 8'd0;
    end else begin
      car_count <= count_nxt;
      err       <= err | err_set;
      hold      <= hold_nxt;
    end
  end

  assign lr_has_car = (car_count != '0) | (hold != 8'd0);

endmodule

// File: tb/tb_lr_car_detector.sv
// Bench for lr_car_detector: two instances (MAX_CARS 15 and 2) against a per-cycle reference model.
module tb_lr_car_detector;
  import tlc_pkg::*;

  localparam int DEB  = DEF_DEB_CYCLES;
  localparam int HOLD = DEF_HOLD_CYCLES;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] arrive_raw = 2'b00;
  logic [1:0] depart_raw = 2'b00;
  logic [1:0] lr_has_car;
  logic [1:0] err;
  logic [3:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lr_car_detector #(.MAX_CARS(15)) dut0 (
    .clk(clk), .rst(rst), .arrive_raw(arrive_raw[0]), .depart_raw(depart_raw[0]),
    .lr_has_car(lr_has_car[0]), .car_count(cnt0), .err(err[0])
  );

  lr_car_detector #(.MAX_CARS(2)) dut1 (
    .clk(clk), .rst(rst), .arrive_raw(arrive_raw[1]), .depart_raw(depart_raw[1]),
    .lr_has_car(lr_has_car[1]), .car_count(cnt1), .err(err[1])
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int max_of(input int d);
    return (d == 0) ? 15 : 2;
  endfunction

  function automatic int count_of(input int d);
    return (d == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  // Reference model: a level flips after DEB consecutive synchronised samples disagreeing with it.
  int       m_count [2];
  int       m_hold  [2];
  bit       m_err   [2];
  int       m_run   [2][2];
  bit       m_lvl   [2][2];
  bit       m_hit   [2][2];
  bit [1:0] m_sync  [2][2];

  always @(posedge clk or posedge rst) begin
    int old, nc, nh, nr;
    bit ne, nl, nhit, samp, rawv;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_count[d] <= 0;
        m_hold[d]  <= 0;
        m_err[d]   <= 1'b0;
        for (int s = 0; s < 2; s++) begin
          m_run[d][s]  <= 0;
          m_lvl[d][s]  <= 1'b0;
          m_hit[d][s]  <= 1'b0;
          m_sync[d][s] <= 2'b00;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        old = m_count[d];
        nc  = old;
        ne  = m_err[d];
        if (m_hit[d][0] && !m_hit[d][1]) begin
          if (old < max_of(d)) nc = old + 1; else ne = 1'b1;
        end else if (m_hit[d][1] && !m_hit[d][0]) begin
          if (old > 0) nc = old - 1; else ne = 1'b1;
        end
        nh = m_hold[d];
        if (nc != 0)      nh = 0;
        else if (old == 1) nh = HOLD;
        else if (nh > 0)  nh = nh - 1;
        m_count[d] <= nc;
        m_err[d]   <= ne;
        m_hold[d]  <= nh;

        for (int s = 0; s < 2; s++) begin
          samp = m_sync[d][s][1];
          nl   = m_lvl[d][s];
          nr   = m_run[d][s];
          nhit = 1'b0;
          if (samp != nl) begin
            nr = nr + 1;
            if (nr == DEB) begin
              nl   = samp;
              nr   = 0;
              nhit = samp;
            end
          end else begin
            nr = 0;
          end
          m_lvl[d][s] <= nl;
          m_run[d][s] <= nr;
          m_hit[d][s] <= nhit;
          rawv = (s == 0) ? arrive_raw[d] : depart_raw[d];
          m_sync[d][s] <= {m_sync[d][s][0], rawv};
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("model_count[%0d]", d), count_of(d), m_count[d]);
      check($sformatf("model_err[%0d]", d), int'(err[d]), int'(m_err[d]));
      check($sformatf("model_lr[%0d]", d), int'(lr_has_car[d]),
            int'((m_count[d] != 0) || (m_hold[d] != 0)));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arrive(input logic [1:0] m);
    @(negedge clk);
    arrive_raw = arrive_raw | m;
    cycles(6);
    arrive_raw = arrive_raw & ~m;
    cycles(6);
  endtask

  task automatic pulse_depart(input logic [1:0] m);
    @(negedge clk);
    depart_raw = depart_raw | m;
    cycles(6);
    depart_raw = depart_raw & ~m;
    cycles(6);
  endtask

  // Assert reset mid-cycle, confirm outputs clear without waiting for an edge.
  task automatic async_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_count0", int'(cnt0), 0);
    check("rst_count1", int'(cnt1), 0);
    check("rst_err", int'(err), 0);
    check("rst_lr", int'(lr_has_car), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [8:0] bounce;

    // Reset at power-up, between edges
    #2 rst = 1'b1;
    #1;
    check("init_count0", int'(cnt0), 0);
    check("init_err", int'(err), 0);
    check("init_lr", int'(lr_has_car), 0);
    cycles(3);
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #3;
      check("idle_count0", int'(cnt0), 0);
      check("idle_lr0", int'(lr_has_car[0]), 0);
    end

    // Clean arrival on both instances: visible after edge k+6, not before
    @(negedge clk);
    arrive_raw = 2'b11;
    for (int j = 0; j <= 6; j++) begin
      @(posedge clk); #3;
      check($sformatf("arr_lat_count0_k%0d", j), int'(cnt0), (j == 6) ? 1 : 0);
      check($sformatf("arr_lat_lr0_k%0d", j), int'(lr_has_car[0]), (j == 6) ? 1 : 0);
    end
    @(negedge clk);
    arrive_raw = 2'b00;
    cycles(8);
    check("arr_count1", int'(cnt1), 1);

    // Bounce on dut0: runs of 3 never debounce
    bounce = 9'b001110111;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      arrive_raw[0] = bounce[i];
    end
    cycles(8);
    check("bounce_count0", int'(cnt0), 1);
    pulse_arrive(2'b01);
    check("steady_count0", int'(cnt0), 2);

    // Departure on dut1 at count 1: lr holds exactly HOLD cycles after count hits 0
    @(negedge clk);
    depart_raw = 2'b10;
    for (int j = 0; j <= 10; j++) begin
      @(posedge clk); #3;
      check($sformatf("dep_count1_k%0d", j), int'(cnt1), (j < 6) ? 1 : 0);
      check($sformatf("dep_lr1_k%0d", j), int'(lr_has_car[1]), (j < 9) ? 1 : 0);
    end
    @(negedge clk);
    depart_raw = 2'b00;
    cycles(8);

    // Saturation on dut1 (MAX_CARS=2)
    pulse_arrive(2'b10);
    pulse_arrive(2'b10);
    pulse_arrive(2'b10);
    cycles(2);
    check("sat_count1", int'(cnt1), 2);
    check("sat_err1", int'(err[1]), 1);
    check("sat_err0", int'(err[0]), 0);

    // Underflow after reset
    async_reset();
    pulse_depart(2'b10);
    check("uf_count1", int'(cnt1), 0);
    check("uf_err1", int'(err[1]), 1);

    // Simultaneous hits at count 3 cancel
    pulse_arrive(2'b01);
    pulse_arrive(2'b01);
    pulse_arrive(2'b01);
    check("pre_sim_count0", int'(cnt0), 3);
    @(negedge clk);
    arrive_raw[0] = 1'b1;
    depart_raw[0] = 1'b1;
    cycles(6);
    arrive_raw[0] = 1'b0;
    depart_raw[0] = 1'b0;
    cycles(6);
    check("sim_count0", int'(cnt0), 3);
    check("sim_err0", int'(err[0]), 0);

    // Reset while in RISE discards progress; a full debounce is needed after release
    @(negedge clk);
    arrive_raw[0] = 1'b1;
    repeat (3) @(posedge clk);
    async_reset();
    for (int j = 0; j <= 6; j++) begin
      @(posedge clk); #3;
      check($sformatf("post_rst_count0_k%0d", j), int'(cnt0), (j == 6) ? 1 : 0);
    end
    @(negedge clk);
    arrive_raw[0] = 1'b0;
    cycles(8);
    check("final_count0", int'(cnt0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
